// File: rtl/pll_sup_pkg.sv
// Shared types and widths for the PLL lock supervisor.
package pll_sup_pkg;

  localparam int TIMEOUT_CNT_W = 4;
  localparam int LOSS_CNT_W    = 8;

  typedef enum logic [1:0] {
    ST_PLL_RST   = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_STABLE    = 2'd2,
    ST_RUN       = 2'd3
  } state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level signal.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [1:0] stage_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_reg <= '0;
    end else begin
      stage_reg <= {stage_reg[0], d};
    end
  end

  assign q = stage_reg[1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// Sequences PLL reset, waits for a stable lock, then releases the core reset.
// Optional lock-loss counter enabled by defining PLL_SUP_LOSS_COUNT_EN.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 65536
) (
  input  logic                     refclk,
  input  logic                     rst_n,
  input  logic                     locked,
  output logic                     pll_rst,
  output logic                     core_reset_n,
  output logic                     ready,
  output logic [TIMEOUT_CNT_W-1:0] timeout_cnt,
  output logic [LOSS_CNT_W-1:0]    loss_cnt
);

  localparam int MAX_CYCLES = max3(PLL_RST_CYCLES, LOCK_STABLE_CYCLES, LOCK_TIMEOUT_CYCLES);
  localparam int CNT_W      = $clog2(MAX_CYCLES);

  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);

  logic                     locked_s;
  state_t                   state_reg, state_next;
  logic [CNT_W-1:0]         cnt_reg, cnt_next;
  logic [TIMEOUT_CNT_W-1:0] timeout_cnt_reg, timeout_cnt_next;
  logic                     pll_rst_reg, core_reset_n_reg, ready_reg;

  sync_2ff u_lock_sync (
    .clk   (refclk),
    .rst_n (rst_n),
    .d     (locked),
    .q     (locked_s)
  );

  // Counter only ever advances below its terminal value, so it cannot wrap.
  always_comb begin
    state_next       = state_reg;
    cnt_next         = cnt_reg;
    timeout_cnt_next = timeout_cnt_reg;
    case (state_reg)
      ST_PLL_RST: begin
        if (cnt_reg == RST_LAST) begin
          state_next = ST_WAIT_LOCK;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      ST_WAIT_LOCK: begin
        if (locked_s) begin
          state_next = ST_STABLE;
          cnt_next   = '0;
        end else if (cnt_reg == TIMEOUT_LAST) begin
          state_next = ST_PLL_RST;
          cnt_next   = '0;
          if (timeout_cnt_reg != '1) begin
            timeout_cnt_next = timeout_cnt_reg + TIMEOUT_CNT_W'(1);
          end
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      ST_STABLE: begin
        // A lock drop wins over reaching the stable count.
        if (!locked_s) begin
          state_next = ST_WAIT_LOCK;
          cnt_next   = '0;
        end else if (cnt_reg == STABLE_LAST) begin
          state_next = ST_RUN;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      ST_RUN: begin
        cnt_next = '0;
        if (!locked_s) begin
          state_next = ST_PLL_RST;
        end
      end
      default: begin
        state_next = ST_PLL_RST;
        cnt_next   = '0;
      end
    endcase
  end

  // Outputs decode the next state so they change on the same edge as the state.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= ST_PLL_RST;
      cnt_reg          <= '0;
      timeout_cnt_reg  <= '0;
      pll_rst_reg      <= 1'b1;
      core_reset_n_reg <= 1'b0;
      ready_reg        <= 1'b0;
    end else begin
      state_reg        <= state_next;
      cnt_reg          <= cnt_next;
      timeout_cnt_reg  <= timeout_cnt_next;
      pll_rst_reg      <= (state_next == ST_PLL_RST);
      core_reset_n_reg <= (state_next == ST_RUN);
      ready_reg        <= (state_next == ST_RUN);
    end
  end

  assign pll_rst      = pll_rst_reg;
  assign core_reset_n = core_reset_n_reg;
  assign ready        = ready_reg;
  assign timeout_cnt  = timeout_cnt_reg;

`ifdef PLL_SUP_LOSS_COUNT_EN
  logic [LOSS_CNT_W-1:0] loss_cnt_reg;

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      loss_cnt_reg <= '0;
    end else if (state_reg == ST_RUN && state_next == ST_PLL_RST && loss_cnt_reg != '1) begin
      loss_cnt_reg <= loss_cnt_reg + LOSS_CNT_W'(1);
    end
  end

  assign loss_cnt = loss_cnt_reg;
`else
  assign loss_cnt = '0;
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor with short reset/stable/timeout windows.
module tb_pll_lock_supervisor;

  logic       refclk = 1'b0;
  logic       rst_n  = 1'b0;
  logic       locked = 1'b0;
  logic       pll_rst, core_reset_n, ready;
  logic [3:0] timeout_cnt;
  logic [7:0] loss_cnt;

  int total = 0;
  int bad   = 0;

`ifdef PLL_SUP_LOSS_COUNT_EN
  localparam bit LOSS_EN = 1'b1;
`else
  localparam bit LOSS_EN = 1'b0;
`endif

  always #5 refclk = ~refclk;

  pll_lock_supervisor #(
    .PLL_RST_CYCLES      (4),
    .LOCK_STABLE_CYCLES  (8),
    .LOCK_TIMEOUT_CYCLES (32)
  ) dut (
    .refclk       (refclk),
    .rst_n        (rst_n),
    .locked       (locked),
    .pll_rst      (pll_rst),
    .core_reset_n (core_reset_n),
    .ready        (ready),
    .timeout_cnt  (timeout_cnt),
    .loss_cnt     (loss_cnt)
  );

  // Advance n rising edges and settle 1 ns past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge refclk);
    #1;
  endtask

  task automatic test_reset();
    int n;
    rst_n = 1'b0; locked = 1'b0;
    tick(2);
    total++; if (pll_rst !== 1'b1) begin bad++; $display("FAIL reset_pll_rst got=%b want=1", pll_rst); end
    total++; if (core_reset_n !== 1'b0) begin bad++; $display("FAIL reset_core_reset_n got=%b want=0", core_reset_n); end
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", ready); end
    total++; if (timeout_cnt !== 4'd0) begin bad++; $display("FAIL reset_timeout_cnt got=%0d want=0", timeout_cnt); end
    total++; if (loss_cnt !== 8'd0) begin bad++; $display("FAIL reset_loss_cnt got=%0d want=0", loss_cnt); end
    rst_n = 1'b1;
    n = 0;
    while (pll_rst === 1'b1 && n < 50) begin tick(1); n++; end
    total++; if (n !== 4) begin bad++; $display("FAIL first_pulse_len got=%0d want=4", n); end
    tick(6);
    locked = 1'b1;
    n = 0;
    while (core_reset_n !== 1'b1 && n < 100) begin tick(1); n++; end
    total++; if (n !== 11) begin bad++; $display("FAIL lock_to_release got=%0d want=11", n); end
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL run_ready got=%b want=1", ready); end
    total++; if (pll_rst !== 1'b0) begin bad++; $display("FAIL run_pll_rst got=%b want=0", pll_rst); end
    $display("test_reset: release after %0d cycles", n);
  endtask

  task automatic test_loss_in_run();
    locked = 1'b0;
    tick(2);
    total++; if (core_reset_n !== 1'b1) begin bad++; $display("FAIL loss_core_early got=%b want=1", core_reset_n); end
    total++; if (pll_rst !== 1'b0) begin bad++; $display("FAIL loss_pll_rst_early got=%b want=0", pll_rst); end
    tick(1);
    total++; if (pll_rst !== 1'b1) begin bad++; $display("FAIL loss_pll_rst got=%b want=1", pll_rst); end
    total++; if (core_reset_n !== 1'b0) begin bad++; $display("FAIL loss_core_reset_n got=%b want=0", core_reset_n); end
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL loss_ready got=%b want=0", ready); end
    total++; if (loss_cnt !== (LOSS_EN ? 8'd1 : 8'd0)) begin bad++; $display("FAIL loss_cnt_one got=%0d want=%0d", loss_cnt, LOSS_EN ? 1 : 0); end
    // 4-cycle pulse plus 32-cycle wait, then one timeout is recorded.
    tick(40);
    total++; if (timeout_cnt !== 4'd1) begin bad++; $display("FAIL loss_then_timeout got=%0d want=1", timeout_cnt); end
    $display("test_loss_in_run: loss_cnt=%0d timeout_cnt=%0d", loss_cnt, timeout_cnt);
  endtask

  task automatic test_rst_mid_run();
    int n;
    locked = 1'b1;
    n = 0;
    while (ready !== 1'b1 && n < 200) begin tick(1); n++; end
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL midrun_reach_run got=%b want=1", ready); end
    @(posedge refclk);
    #3 rst_n = 1'b0;
    #1;
    total++; if (pll_rst !== 1'b1) begin bad++; $display("FAIL async_pll_rst got=%b want=1", pll_rst); end
    total++; if (core_reset_n !== 1'b0) begin bad++; $display("FAIL async_core_reset_n got=%b want=0", core_reset_n); end
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL async_ready got=%b want=0", ready); end
    total++; if (timeout_cnt !== 4'd0) begin bad++; $display("FAIL async_timeout_cnt got=%0d want=0", timeout_cnt); end
    total++; if (loss_cnt !== 8'd0) begin bad++; $display("FAIL async_loss_cnt got=%0d want=0", loss_cnt); end
    tick(2);
    rst_n = 1'b1;
    n = 0;
    while (pll_rst === 1'b1 && n < 50) begin tick(1); n++; end
    total++; if (n !== 4) begin bad++; $display("FAIL midrun_pulse_len got=%0d want=4", n); end
    $display("test_rst_mid_run: pulse=%0d", n);
  endtask

  task automatic test_stable_glitch();
    int n;
    rst_n = 1'b0; locked = 1'b0;
    tick(2);
    rst_n = 1'b1;
    n = 0;
    while (pll_rst === 1'b1 && n < 50) begin tick(1); n++; end
    total++; if (n !== 4) begin bad++; $display("FAIL glitch_pulse_len got=%0d want=4", n); end
    locked = 1'b1;
    tick(6);
    locked = 1'b0;
    tick(1);
    locked = 1'b1;
    n = 7;
    while (core_reset_n !== 1'b1 && n < 100) begin tick(1); n++; end
    // 11 cycles without the glitch; the drop costs 7 more for the restart.
    total++; if (n !== 18) begin bad++; $display("FAIL glitch_release got=%0d want=18", n); end
    $display("test_stable_glitch: release after %0d cycles", n);
  endtask

  task automatic test_timeout();
    int n;
    rst_n = 1'b0; locked = 1'b0;
    tick(2);
    rst_n = 1'b1;
    for (int k = 1; k <= 2; k++) begin
      n = 0;
      while (pll_rst === 1'b1 && n < 50) begin tick(1); n++; end
      total++; if (n !== 4) begin bad++; $display("FAIL timeout_pulse_len[%0d] got=%0d want=4", k, n); end
      n = 0;
      while (pll_rst !== 1'b1 && n < 100) begin tick(1); n++; end
      total++; if (n !== 32) begin bad++; $display("FAIL timeout_wait_len[%0d] got=%0d want=32", k, n); end
      total++; if (timeout_cnt !== 4'(k)) begin bad++; $display("FAIL timeout_cnt[%0d] got=%0d want=%0d", k, timeout_cnt, k); end
    end
    tick(36 * 13);
    total++; if (timeout_cnt !== 4'd15) begin bad++; $display("FAIL timeout_reach15 got=%0d want=15", timeout_cnt); end
    tick(36 * 3);
    total++; if (timeout_cnt !== 4'd15) begin bad++; $display("FAIL timeout_saturate got=%0d want=15", timeout_cnt); end
    $display("test_timeout: timeout_cnt=%0d", timeout_cnt);
  endtask

  task automatic run_losses(input int count, inout int stuck);
    int n;
    for (int i = 0; i < count; i++) begin
      locked = 1'b1;
      n = 0;
      while (ready !== 1'b1 && n < 100) begin tick(1); n++; end
      if (n >= 100) stuck++;
      locked = 1'b0;
      n = 0;
      while (pll_rst !== 1'b1 && n < 10) begin tick(1); n++; end
      if (n >= 10) stuck++;
    end
  endtask

  task automatic test_loss_saturate();
    int stuck;
    int n1, n2;
    stuck = 0;
    n1 = LOSS_EN ? 254 : 2;
    n2 = LOSS_EN ? 46 : 1;
    rst_n = 1'b0; locked = 1'b0;
    tick(2);
    rst_n = 1'b1;
    run_losses(n1, stuck);
    total++; if (loss_cnt !== (LOSS_EN ? 8'd254 : 8'd0)) begin bad++; $display("FAIL loss_cnt_254 got=%0d want=%0d", loss_cnt, LOSS_EN ? 254 : 0); end
    run_losses(n2, stuck);
    total++; if (loss_cnt !== (LOSS_EN ? 8'd255 : 8'd0)) begin bad++; $display("FAIL loss_cnt_sat got=%0d want=%0d", loss_cnt, LOSS_EN ? 255 : 0); end
    total++; if (stuck !== 0) begin bad++; $display("FAIL loss_loop_waits got=%0d want=0", stuck); end
    $display("test_loss_saturate: losses=%0d loss_cnt=%0d", n1 + n2, loss_cnt);
  endtask

  initial begin
    test_reset();
    test_loss_in_run();
    test_rst_mid_run();
    test_stable_glitch();
    test_timeout();
    test_loss_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pll_lock_supervisor.md
PLL_LOCK_SUPERVISOR -- requirements
Module: pll_lock_supervisor

Interface
REQ-001 SHALL have parameter PLL_RST_CYCLES, default 16: cycles `pll_rst` is held high per reset pulse, minimum 1.
REQ-002 SHALL have parameter LOCK_STABLE_CYCLES, default 1024: consecutive synchronized-lock cycles required before release, minimum 1.
REQ-003 SHALL have parameter LOCK_TIMEOUT_CYCLES, default 65536: cycles to wait for lock before re-pulsing `pll_rst`, minimum 2.
REQ-004 SHALL have port `refclk`, input, 1 bit: the single clock, the free-running PLL reference.
REQ-005 SHALL have port `rst_n`, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port `locked`, input, 1 bit: PLL lock indication, asynchronous to `refclk`.
REQ-007 SHALL have port `pll_rst`, output, 1 bit: active-high reset driven to the PLL `rst` input.
REQ-008 SHALL have port `core_reset_n`, output, 1 bit: active-low reset for logic clocked by the PLL outputs.
REQ-009 SHALL have port `ready`, output, 1 bit: high while in RUN.
REQ-010 SHALL have port `timeout_cnt`, output, 4 bits: saturating count of lock timeouts.
REQ-011 SHALL have port `loss_cnt`, output, 8 bits: saturating count of lock losses seen in RUN.

Function
REQ-012 SHALL pass `locked` through a 2-flop synchronizer to form `locked_s`, giving 2 cycles of latency.
REQ-013 SHALL implement states PLL_RST, WAIT_LOCK, STABLE and RUN; all outputs SHALL be registered.
REQ-014 PLL_RST SHALL:
- drive `pll_rst`=1 and `core_reset_n`=0;
- last exactly PLL_RST_CYCLES cycles;
- then go to WAIT_LOCK with the cycle counter cleared.
REQ-015 WAIT_LOCK SHALL drive `pll_rst`=0 and:
- go to STABLE with the counter cleared when `locked_s`=1;
- otherwise, on counter = LOCK_TIMEOUT_CYCLES-1, go to PLL_RST and increment `timeout_cnt`, saturating at 15.
REQ-016 STABLE SHALL:
- count consecutive cycles with `locked_s`=1;
- return to WAIT_LOCK with the counter cleared on any `locked_s`=0;
- go to RUN when the count reaches LOCK_STABLE_CYCLES.
REQ-017 RUN SHALL drive `core_reset_n`=1 and `ready`=1; `locked_s`=0 SHALL send the FSM to PLL_RST.
REQ-018 On RUN exit, `core_reset_n` and `ready` SHALL fall in the same cycle `pll_rst` rises, i.e. one cycle after `locked_s` falls.
REQ-019 If `locked_s`=0 and the timeout terminal count occur in the same cycle, timeout SHALL take precedence; in STABLE, the lock drop SHALL take precedence over reaching the count.
REQ-020 The cycle counter SHALL be sized to the largest of the three parameters, $clog2-based, and SHALL never wrap.

Reset
REQ-021 Asserting `rst_n` low SHALL asynchronously force:
- state PLL_RST, counters 0, synchronizer flops 0;
- `pll_rst`=1, `core_reset_n`=0, `ready`=0, `timeout_cnt`=0, `loss_cnt`=0.
REQ-022 After `rst_n` deasserts, the first PLL_RST pulse SHALL be a full PLL_RST_CYCLES long, even if `rst_n` was asserted mid-operation.

Configuration
REQ-023 With macro PLL_SUP_LOSS_COUNT_EN defined, `loss_cnt` SHALL increment by 1 on each RUN-to-PLL_RST transition, saturating at 255.
REQ-024 Without PLL_SUP_LOSS_COUNT_EN, `loss_cnt` SHALL be constant 0 and no counter register SHALL be synthesized; the port SHALL remain.

Structure
REQ-025 Package pll_sup_pkg SHALL hold:
- the state enum typedef;
- TIMEOUT_CNT_W=4 and LOSS_CNT_W=8.
REQ-026 The synchronizer SHALL be sub-module sync_2ff (1-bit, async active-low reset to 0), instantiated once.

Verification
Bench parameters are PLL_RST_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32.
REQ-027 Bench SHALL cover these scenarios:
- `rst_n` release with `locked` rising 10 cycles later and held -> `pll_rst` high for exactly 4 cycles, `core_reset_n` rises 2+8+1 cycles after `locked` (sync latency, stable count, output register), `ready`=1.
- `locked` held 0 -> `pll_rst` re-pulses every 4+32 cycles, `timeout_cnt` reaches 15 and stays there.
- In STABLE, `locked` glitches low for 1 cycle after 5 good cycles -> FSM returns to WAIT_LOCK, and the full 8-cycle stable count restarts.
- In RUN, `locked` drops -> `core_reset_n`=0 and `pll_rst`=1 exactly 3 cycles later; `loss_cnt`=1 with the macro defined, 0 without.
- `rst_n` asserted mid-RUN -> all outputs return to reset values immediately (asynchronously), and the next `pll_rst` pulse is 4 cycles long.
- 300 lock losses with the macro defined -> `loss_cnt`=255.
